vppm_tx: RTL and testbench
==========================

Name: vppm_tx

Overview:
- Serial VPPM modulator: the transmitting end of the link whose receiver detects symbol frequency from a zero run, then demodulates continuously.
- Accepts NBITS-wide words over a valid/ready handshake.
- Emits a frame on one line: preamble of '0' symbols, one sync '1' symbol, then data symbols MSB first.
- Back-to-back words stream without a new preamble.
- Sits in the same clk domain as the receiver (200 MHz PLL output); replaces the simulation-only signal source.

Parameters:
- NBITS, 12, data word width.
- PREAMBLE_BITS, 8, '0' symbols before sync; must be >=5, elaboration error otherwise.
- HLW, 16, width of the half-symbol length input.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- half_len  in  HLW  clocks per half-symbol; sampled only at frame start.
- din  in  NBITS  data word.
- din_valid  in  1  din holds a valid word.
- din_ready  out  1  block accepts din this cycle.
- vppm_out  out  1  modulated line, registered.
- frame_active  out  1  high from first preamble clock to last data clock of the frame.
- underrun  out  1  one-cycle pulse when streaming ends because no word was ready.

Behaviour:
- Reset (async, reset_n=0): state IDLE; vppm_out=0; din_ready=0; frame_active=0; underrun=0; all counters 0.
- din_ready is 1 in the first cycle after reset release.
- Symbol = 2*H clocks, H = latched half_len. If half_len<2 then H=2.
- Bit '0': vppm_out=1 for the first H clocks, 0 for the second H clocks.
- Bit '1': vppm_out=0 for the first H clocks, 1 for the second H clocks.
- FSM states: IDLE, PREAMBLE, SYNC, DATA.
  - IDLE: din_ready=1, vppm_out=0. On din_valid&din_ready, latch din to shift register and half_len to H; go to PREAMBLE.
  - Latency: the first preamble clock (vppm_out=1) is the cycle after acceptance.
  - PREAMBLE: PREAMBLE_BITS '0' symbols, then SYNC.
  - SYNC: one '1' symbol, then DATA.
  - DATA: NBITS symbols, MSB first.
- Word handoff:
  - din_ready=1 only on the last clock of the last data symbol.
  - If a word is accepted then, the next word's MSB symbol starts the following clock: no gap, no preamble, H unchanged.
  - Otherwise go to IDLE, pulse underrun for 1 cycle, drop frame_active.
- Counters:
  - phase counter 0..H-1.
  - half flag.
  - bit counter width $clog2(max(PREAMBLE_BITS,NBITS)+1).
  - No wrap except at the defined terminal counts.
- half_len changes mid-frame are ignored until the next IDLE->PREAMBLE transition.
- din_valid while din_ready=0: held by the producer per the handshake; the block never samples din then.
- reset_n low mid-frame: output forced low immediately; the partially sent word is lost.

Optional Feature:
- Macro VPPM_DIMMING_EN.
- Defined:
  - Adds input pulse_len [HLW:0], latched with H.
  - Bit '0' is high for clocks 0..P-1 of the symbol; bit '1' is high for clocks 2H-P..2H-1.
  - P = pulse_len clamped to 1..2H-1.
  - Gives dimming while keeping pulse position encoding.
- Undefined: port absent; P fixed at H (50% duty), exactly as above.

Decomposition:
- Package vppm_pkg holds:
  - state enum (IDLE, PREAMBLE, SYNC, DATA);
  - VPPM_MIN_PREAMBLE=5;
  - VPPM_SYNC_SYMBOL=1'b1;
  - clamp constants.
- One sub-module: vppm_symbol_gen.
  - Takes bit value, H, P and a start strobe.
  - Produces the pulse waveform and a symbol_done strobe on the last clock.
- The top FSM handles framing and the handshake.

Test Plan:
- Reset with NBITS=12, half_len=4: vppm_out=0, frame_active=0 during reset; din_ready=1 the cycle after release.
- Accept din=12'hAAA with half_len=4:
  - 8 preamble symbols of 4 high/4 low (64 clocks);
  - sync symbol 4 low/4 high;
  - data symbols alternating 1,0,...;
  - frame_active high exactly 168 clocks;
  - underrun pulses once after them.
- Two words 12'hF00, 12'h00F offered back-to-back: the second word starts the clock after the first word's last data clock; no preamble between; 264 clocks total of frame_active.
- half_len=0 and half_len=1: symbol length is 4 clocks (H clamped to 2); half_len changed to 9 mid-frame does not alter symbol length.
- reset_n asserted during the 5th data symbol: vppm_out low asynchronously; after release, a fresh word restarts with a full preamble.
- VPPM_DIMMING_EN with half_len=4, pulse_len=2: bit '0' gives high clocks 0-1; bit '1' gives high clocks 6-7; pulse_len=0 is treated as 1; pulse_len=12 is treated as 7.

Source files
------------

// File: rtl/vppm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// vppm_pkg : shared state encoding and constants for the VPPM transmitter
// Rev 1.0
// ----------------------------------------------------------------------------
package vppm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    SYNC     = 2'd2,
    DATA     = 2'd3
  } vppm_state_t;

  localparam int   VPPM_MIN_PREAMBLE    = 5;
  localparam logic VPPM_SYNC_SYMBOL     = 1'b1;
  localparam logic VPPM_PREAMBLE_SYMBOL = 1'b0;
  localparam int   VPPM_MIN_HALF        = 2;
  localparam int   VPPM_MIN_PULSE       = 1;

endpackage
`default_nettype wire

// File: rtl/vppm_symbol_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// vppm_symbol_gen : one pulse-position symbol of 2*H clocks, registered output
// Rev 1.0
// ----------------------------------------------------------------------------
module vppm_symbol_gen
  import vppm_pkg::*;
#(
  parameter int HLW = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           bit_val,
  input  logic [HLW-1:0] h_in,
  input  logic [HLW:0]   p_in,
  output logic           pulse,
  output logic           symbol_done
);

  logic           r_active, r_half, r_bit, r_pulse;
  logic [HLW-1:0] r_phase, r_h;
  logic [HLW:0]   r_p;

  logic           w_active, w_half, w_bit, w_pulse, w_last_phase;
  logic [HLW-1:0] w_phase, w_h;
  logic [HLW:0]   w_p, w_pos, w_rise;

  assign w_last_phase = (r_phase == (r_h - HLW'(1)));
  assign symbol_done  = r_active && r_half && w_last_phase;
  assign pulse        = r_pulse;

  // The output register holds the level of the clock being computed here,
  // so a start strobe shows position 0 on the very next clock.
  always_comb begin
    w_active = r_active;
    w_half   = r_half;
    w_bit    = r_bit;
    w_phase  = r_phase;
    w_h      = r_h;
    w_p      = r_p;
    if (start) begin
      w_active = 1'b1;
      w_half   = 1'b0;
      w_phase  = '0;
      w_bit    = bit_val;
      w_h      = h_in;
      w_p      = p_in;
    end else if (r_active) begin
      if (w_last_phase) begin
        w_phase = '0;
        w_half  = ~r_half;
        if (r_half) w_active = 1'b0;
      end else begin
        w_phase = r_phase + HLW'(1);
      end
    end
    w_pos   = w_half ? ({1'b0, w_h} + {1'b0, w_phase}) : {1'b0, w_phase};
    w_rise  = {w_h, 1'b0} - w_p;
    w_pulse = w_active && (w_bit ? (w_pos >= w_rise) : (w_pos < w_p));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active <= 1'b0;
      r_half   <= 1'b0;
      r_bit    <= 1'b0;
      r_pulse  <= 1'b0;
      r_phase  <= '0;
      r_h      <= '0;
      r_p      <= '0;
    end else begin
      r_active <= w_active;
      r_half   <= w_half;
      r_bit    <= w_bit;
      r_pulse  <= w_pulse;
      r_phase  <= w_phase;
      r_h      <= w_h;
      r_p      <= w_p;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vppm_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// vppm_tx : VPPM framer (preamble, sync, streamed MSB-first data words)
// Optional macro VPPM_DIMMING_EN adds pulse_len for duty-cycle dimming.
// Rev 1.0
// ----------------------------------------------------------------------------
module vppm_tx
  import vppm_pkg::*;
#(
  parameter int NBITS         = 12,
  parameter int PREAMBLE_BITS = 8,
  parameter int HLW           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [HLW-1:0]   half_len,
`ifdef VPPM_DIMMING_EN
  input  logic [HLW:0]     pulse_len,
`endif
  input  logic [NBITS-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             vppm_out,
  output logic             frame_active,
  output logic             underrun
);

  localparam int c_bc_max = (PREAMBLE_BITS > NBITS) ? PREAMBLE_BITS : NBITS;
  localparam int c_bcw    = $clog2(c_bc_max + 1);
  localparam logic [c_bcw-1:0] c_pre_last  = c_bcw'(PREAMBLE_BITS - 1);
  localparam logic [c_bcw-1:0] c_data_last = c_bcw'(NBITS - 1);
  localparam logic [c_bcw-1:0] c_bc_one    = c_bcw'(1);

  if (PREAMBLE_BITS < VPPM_MIN_PREAMBLE) begin : g_preamble_check
    $error("vppm_tx: PREAMBLE_BITS must be at least 5");
  end

  vppm_state_t      r_state, w_state_next;
  logic [c_bcw-1:0] r_bitcnt, w_bitcnt_next;
  logic [NBITS-1:0] r_shreg, w_shreg_next, w_shifted;
  logic [HLW-1:0]   r_h, w_h_clamp, w_h_sel;
  logic [HLW:0]     r_p, w_p_clamp, w_p_sel;
  logic             r_armed, r_underrun, w_underrun_next;
  logic             w_sym_start, w_sym_bit, w_sym_done, w_accept, w_last_data;

  assign w_h_clamp = (half_len < HLW'(VPPM_MIN_HALF)) ? HLW'(VPPM_MIN_HALF) : half_len;

`ifdef VPPM_DIMMING_EN
  logic [HLW:0] w_p_max;
  assign w_p_max   = {w_h_clamp, 1'b0} - (HLW+1)'(1);
  assign w_p_clamp = (pulse_len < (HLW+1)'(VPPM_MIN_PULSE)) ? (HLW+1)'(VPPM_MIN_PULSE) :
                     (pulse_len > w_p_max) ? w_p_max : pulse_len;
`else
  assign w_p_clamp = {1'b0, w_h_clamp};
`endif

  // Timing is taken from the inputs only for the first symbol of a frame.
  assign w_h_sel = (r_state == IDLE) ? w_h_clamp : r_h;
  assign w_p_sel = (r_state == IDLE) ? w_p_clamp : r_p;

  assign w_last_data  = (r_state == DATA) && w_sym_done && (r_bitcnt == c_data_last);
  assign din_ready    = r_armed && ((r_state == IDLE) || w_last_data);
  assign w_accept     = din_valid && din_ready;
  assign w_shifted    = r_shreg << 1;
  assign frame_active = (r_state != IDLE);
  assign underrun     = r_underrun;

  always_comb begin
    w_state_next    = r_state;
    w_bitcnt_next   = r_bitcnt;
    w_shreg_next    = r_shreg;
    w_sym_start     = 1'b0;
    w_sym_bit       = 1'b0;
    w_underrun_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next  = PREAMBLE;
          w_sym_start   = 1'b1;
          w_sym_bit     = VPPM_PREAMBLE_SYMBOL;
          w_bitcnt_next = '0;
          w_shreg_next  = din;
        end
      end
      PREAMBLE: begin
        if (w_sym_done) begin
          w_sym_start = 1'b1;
          if (r_bitcnt == c_pre_last) begin
            w_state_next  = SYNC;
            w_sym_bit     = VPPM_SYNC_SYMBOL;
            w_bitcnt_next = '0;
          end else begin
            w_sym_bit     = VPPM_PREAMBLE_SYMBOL;
            w_bitcnt_next = r_bitcnt + c_bc_one;
          end
        end
      end
      SYNC: begin
        if (w_sym_done) begin
          w_state_next  = DATA;
          w_sym_start   = 1'b1;
          w_sym_bit     = r_shreg[NBITS-1];
          w_bitcnt_next = '0;
        end
      end
      DATA: begin
        if (w_sym_done) begin
          if (r_bitcnt == c_data_last) begin
            if (w_accept) begin
              w_sym_start   = 1'b1;
              w_sym_bit     = din[NBITS-1];
              w_shreg_next  = din;
              w_bitcnt_next = '0;
            end else begin
              w_state_next    = IDLE;
              w_underrun_next = 1'b1;
            end
          end else begin
            w_sym_start   = 1'b1;
            w_sym_bit     = w_shifted[NBITS-1];
            w_shreg_next  = w_shifted;
            w_bitcnt_next = r_bitcnt + c_bc_one;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bitcnt   <= '0;
      r_shreg    <= '0;
      r_h        <= '0;
      r_p        <= '0;
      r_armed    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_bitcnt   <= w_bitcnt_next;
      r_shreg    <= w_shreg_next;
      r_armed    <= 1'b1;
      r_underrun <= w_underrun_next;
      if ((r_state == IDLE) && w_accept) begin
        r_h <= w_h_clamp;
        r_p <= w_p_clamp;
      end
    end
  end

  vppm_symbol_gen #(.HLW(HLW)) u_symbol_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (w_sym_start),
    .bit_val     (w_sym_bit),
    .h_in        (w_h_sel),
    .p_in        (w_p_sel),
    .pulse       (vppm_out),
    .symbol_done (w_sym_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_vppm_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vppm_tx : self-checking bench for vppm_tx against a per-clock line model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_vppm_tx;

  localparam int NBITS = 12;
  localparam int PRE   = 8;
  localparam int HLW   = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [HLW-1:0]   half_len;
  logic [HLW:0]     pulse_len;
  logic [NBITS-1:0] din;
  logic             din_valid;
  logic             din_ready, vppm_out, frame_active, underrun;

  int vectors     = 0;
  int miscompares = 0;

  // {vppm_out, frame_active, underrun, din_ready} expected per clock
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  vppm_tx #(.NBITS(NBITS), .PREAMBLE_BITS(PRE), .HLW(HLW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .half_len     (half_len),
`ifdef VPPM_DIMMING_EN
    .pulse_len    (pulse_len),
`endif
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .vppm_out     (vppm_out),
    .frame_active (frame_active),
    .underrun     (underrun)
  );

  function automatic logic wave(input logic b, input int i, input int h, input int p);
    if (b) return (i >= 2*h - p);
    return (i < p);
  endfunction

  function automatic int model_h(input int hl);
    return (hl < 2) ? 2 : hl;
  endfunction

  function automatic int model_p(input int pl, input int h);
`ifdef VPPM_DIMMING_EN
    if (pl < 1) return 1;
    if (pl > 2*h - 1) return 2*h - 1;
    return pl;
`else
    return (pl < 0) ? h : h;
`endif
  endfunction

  task automatic push_sym(input logic b, input int h, input int p, input logic rdy_last);
    for (int i = 0; i < 2*h; i++)
      exp_q.push_back({wave(b, i, h, p), 1'b1, 1'b0, rdy_last && (i == 2*h - 1)});
  endtask

  task automatic build_model(input logic [NBITS-1:0] words[$], input int h, input int p);
    logic [NBITS-1:0] w;
    exp_q.delete();
    for (int s = 0; s < PRE; s++) push_sym(1'b0, h, p, 1'b0);
    push_sym(1'b1, h, p, 1'b0);
    for (int k = 0; k < words.size(); k++) begin
      w = words[k];
      for (int b = NBITS - 1; b >= 0; b--) push_sym(w[b], h, p, b == 0);
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0001);
  endtask

  task automatic send_words(input string name, input logic [NBITS-1:0] words[$],
                            input int hl, input int pl, input int hl_mid_at,
                            input int abort_at, output int fa_cnt, output int un_cnt);
    int h, p, acc, t;
    logic [3:0] act;
    logic acc_now;
    h = model_h(hl);
    p = model_p(pl, h);
    build_model(words, h, p);
    fa_cnt = 0;
    un_cnt = 0;
    @(negedge clk);
    half_len  = HLW'(hl);
    pulse_len = (HLW+1)'(pl);
    din       = words[0];
    din_valid = 1'b1;
    t = 0;
    while (din_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (din_ready !== 1'b1) begin
      $display("FAIL %s handshake: din_ready=%b required 1", name, din_ready);
      miscompares++;
      din_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = 1;
    if (acc < words.size()) din = words[acc];
    else begin din_valid = 1'b0; din = NBITS'($urandom); end
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      if (c == hl_mid_at) half_len = HLW'(9);
      act = {vppm_out, frame_active, underrun, din_ready};
      if (frame_active === 1'b1) fa_cnt++;
      if (underrun === 1'b1) un_cnt++;
      vectors++;
      if (act !== exp_q[c]) begin
        $display("FAIL %s clk %0d: out/fa/un/rdy=%b required %b", name, c, act, exp_q[c]);
        miscompares++;
      end
      if (c == abort_at) begin
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({vppm_out, frame_active} !== 2'b00) begin
          $display("FAIL %s async reset: out/fa=%b required 00", name, {vppm_out, frame_active});
          miscompares++;
        end
        din_valid = 1'b0;
        return;
      end
      acc_now = din_valid && din_ready;
      if (acc_now) begin
        @(posedge clk);
        #1;
        acc++;
        if (acc < words.size()) din = words[acc];
        else begin din_valid = 1'b0; din = NBITS'($urandom); end
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; din_valid = 1'b0; din = '0; half_len = HLW'(4); pulse_len = '0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({vppm_out, frame_active, din_ready, underrun} !== 4'b0000) begin
        $display("FAIL reset_hold: out/fa/rdy/un=%b required 0000",
                 {vppm_out, frame_active, din_ready, underrun});
        miscompares++;
      end
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({din_ready, frame_active, vppm_out} !== 3'b100) begin
      $display("FAIL reset_release: rdy/fa/out=%b required 100", {din_ready, frame_active, vppm_out});
      miscompares++;
    end
  endtask

  task automatic test_single();
    logic [NBITS-1:0] q[$];
    int fa, un;
    q = '{12'hAAA};
    send_words("single_AAA", q, 4, -1, -1, -1, fa, un);
    vectors++;
    if (fa != 168 || un != 1) begin
      $display("FAIL single_counts: frame_active=%0d underrun=%0d required 168 1", fa, un);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [NBITS-1:0] q[$];
    int fa, un;
    q = '{12'hF00, 12'h00F};
    send_words("b2b", q, 4, -1, -1, -1, fa, un);
    vectors++;
    if (fa != 264 || un != 1) begin
      $display("FAIL b2b_counts: frame_active=%0d underrun=%0d required 264 1", fa, un);
      miscompares++;
    end
  endtask

  task automatic test_half_clamp();
    logic [NBITS-1:0] q[$];
    int fa, un;
    q = '{NBITS'($urandom)};
    send_words("half_len0", q, 0, -1, -1, -1, fa, un);
    q = '{NBITS'($urandom)};
    send_words("half_len1_mid9", q, 1, -1, 40, -1, fa, un);
    vectors++;
    if (fa != (PRE + 1 + NBITS) * 4) begin
      $display("FAIL clamp_len: frame_active=%0d required %0d", fa, (PRE + 1 + NBITS) * 4);
      miscompares++;
    end
  endtask

  task automatic test_random();
    logic [NBITS-1:0] q[$];
    int fa, un, n;
    for (int r = 0; r < 4; r++) begin
      q.delete();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) q.push_back(NBITS'($urandom));
      send_words("random", q, $urandom_range(2, 6), -1, 60, -1, fa, un);
    end
  endtask

  task automatic test_reset_mid();
    logic [NBITS-1:0] q[$];
    int fa, un;
    q = '{12'hAAA};
    send_words("reset_mid", q, 4, -1, -1, (PRE + 1) * 8 + 4 * 8 + 5, fa, un);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (din_ready !== 1'b1) begin
      $display("FAIL reset_mid_release: din_ready=%b required 1", din_ready);
      miscompares++;
    end
    q = '{NBITS'($urandom)};
    send_words("after_reset", q, 4, -1, -1, -1, fa, un);
  endtask

`ifdef VPPM_DIMMING_EN
  task automatic test_dimming();
    logic [NBITS-1:0] q[$];
    int fa, un;
    q = '{12'hA5C};
    send_words("dim_p2", q, 4, 2, -1, -1, fa, un);
    q = '{NBITS'($urandom)};
    send_words("dim_p0", q, 4, 0, -1, -1, fa, un);
    q = '{NBITS'($urandom), NBITS'($urandom)};
    send_words("dim_p12", q, 4, 12, -1, -1, fa, un);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_half_clamp();
    test_random();
    test_reset_mid();
`ifdef VPPM_DIMMING_EN
    test_dimming();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
